ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register plus memory-access sequencer. Sits directly downstream of the EX stage, which is fed by the ID/EX register.
- Captures EX results, drives the data-memory port for LDR/STR/LDB/STB/LDI/STI, and presents completed results to MEM/WB.
- Generates the global stall_pipeline that freezes all upstream pipeline registers while an access is outstanding.

Parameters:
- WIDTH, 16, datapath/address width (LC-3b word).
- REGW, 3, destination register index width.

Ports:
- clk in 1: clock, all state on rising edge.
- reset_n in 1: asynchronous active-low reset.
- valid_in in 1: EX slot holds a real instruction.
- flush in 1: squash the instruction being captured.
- alu_in in WIDTH: ALU result / effective address.
- store_data_in in WIDTH: SR data for stores.
- dest_in in REGW: destination register.
- pc_in in WIDTH: PC of the instruction.
- mem_read_in in 1: load op.
- mem_write_in in 1: store op.
- indirect_in in 1: LDI/STI.
- byte_in in 1: LDB/STB.
- load_regfile_in in 1: writes regfile.
- dmem_rdata in WIDTH: memory read data.
- dmem_resp in 1: access complete this cycle.
- dmem_read out 1: read request.
- dmem_write out 1: write request.
- dmem_address out WIDTH: access address.
- dmem_wdata out WIDTH: write data.
- dmem_byte_enable out 2: byte lanes.
- valid_out out 1: completed instruction presented to MEM/WB.
- alu_out out WIDTH: registered ALU result.
- mem_data_out out WIDTH: load result.
- dest_out out REGW: registered destination register.
- pc_out out WIDTH: registered PC.
- load_regfile_out out 1: registered regfile write enable.
- stall_pipeline out 1: freeze upstream.

Behaviour:
- Reset (async, reset_n=0): all pipeline regs and mem_data = 0; ind_addr = 0; state = IDLE. All outputs read 0.
- State machine, encoded in 2 bits: IDLE, IND, ACC.
- stall_pipeline = (state != IDLE). Combinational from state only.
- Capture on posedge when stall_pipeline = 0:
  - All *_in fields are registered.
  - valid_reg <= valid_in & ~flush.
  - Next state = IND if the captured op is valid, is a read or write, and has indirect_in = 1.
  - Next state = ACC if valid, read or write, and not indirect.
  - Otherwise next state = IDLE.
- While stall_pipeline = 1, pipeline regs hold; flush and valid_in are ignored.
- IND state:
  - dmem_read = 1; dmem_address = {alu[15:1],0}.
  - On dmem_resp: ind_addr <= dmem_rdata; state goes to ACC.
- ACC state:
  - Address A = indirect ? ind_addr : alu.
  - Word access: dmem_address = {A[15:1],0}, byte_enable = 11, wdata = store_data.
  - Byte access: dmem_address = A, byte_enable = A[0] ? 10 : 01, wdata = {store_data[7:0], store_data[7:0]}.
  - dmem_read = mem_read; dmem_write = mem_write.
  - On dmem_resp: mem_data <= word ? dmem_rdata : zero-extended byte (A[0] ? rdata[15:8] : rdata[7:0]); state goes to IDLE.
- dmem_read, dmem_write and byte_enable are 0 in IDLE. Requests are held stable until dmem_resp.
- valid_out = valid_reg & (state == IDLE). A memory op becomes visible the cycle after its resp. A non-memory op is visible the cycle after capture.
- Latency, memory op with a 1-cycle resp: capture edge E0 → ACC; resp edge E1 → IDLE with valid_out = 1; next capture at E2. Indirect ops add one IND phase.
- A dmem_resp arriving in IDLE is ignored.
- Reset mid-IND or mid-ACC: requests drop immediately, and the instruction is discarded.

Test Plan:
- ADD: valid_in=1, alu_in=0x1234, dest 3, load_regfile=1 → next cycle valid_out=1, alu_out=0x1234, dest_out=3, stall_pipeline never asserted.
- LDR: alu_in=0x3001, resp after 3 cycles with rdata 0xBEEF → dmem_address=0x3000, byte_enable=11, stall high for exactly 3 cycles, then mem_data_out=0xBEEF with valid_out=1.
- LDB odd: alu_in=0x4005, rdata=0xA55A → dmem_address=0x4005, mem_data_out=0x00A5. Even address 0x4004 → 0x005A.
- STB odd: alu_in=0x5001, store_data=0x12CD → dmem_write=1, byte_enable=10, wdata=0xCDCD, dmem_read=0.
- LDI: alu_in=0x6000, first rdata=0x7002, second rdata=0x0042 → addresses 0x6000 then 0x7002, mem_data_out=0x0042, stall for both phases.
- Flush and reset: flush=1 at capture → valid_out=0, no dmem request. reset_n low during ACC → dmem_read=0 asynchronously, state IDLE, stall_pipeline=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a data-memory sequencer for LDR/STR/LDB/STB/LDI/STI.
// Holds the upstream pipeline via stall_pipeline while an access is outstanding.
module ex_mem_stage #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] store_data_in,
    input  logic [REGW-1:0]  dest_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             indirect_in,
    input  logic             byte_in,
    input  logic             load_regfile_in,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_resp,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [WIDTH-1:0] dmem_address,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output logic             valid_out,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] mem_data_out,
    output logic [REGW-1:0]  dest_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             load_regfile_out,
    output logic             stall_pipeline
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t           state;
    logic             valid_reg;
    logic [WIDTH-1:0] alu_reg;
    logic [WIDTH-1:0] store_data_reg;
    logic [REGW-1:0]  dest_reg;
    logic [WIDTH-1:0] pc_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic             indirect_reg;
    logic             byte_reg;
    logic             load_regfile_reg;
    logic [WIDTH-1:0] mem_data_reg;
    logic [WIDTH-1:0] ind_addr;
    logic [WIDTH-1:0] acc_addr;
    logic [7:0]       rdata_byte;

    assign acc_addr   = indirect_reg ? ind_addr : alu_reg;
    assign rdata_byte = acc_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            valid_reg        <= 1'b0;
            alu_reg          <= '0;
            store_data_reg   <= '0;
            dest_reg         <= '0;
            pc_reg           <= '0;
            mem_read_reg     <= 1'b0;
            mem_write_reg    <= 1'b0;
            indirect_reg     <= 1'b0;
            byte_reg         <= 1'b0;
            load_regfile_reg <= 1'b0;
            mem_data_reg     <= '0;
            ind_addr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_reg        <= valid_in & ~flush;
                    alu_reg          <= alu_in;
                    store_data_reg   <= store_data_in;
                    dest_reg         <= dest_in;
                    pc_reg           <= pc_in;
                    mem_read_reg     <= mem_read_in;
                    mem_write_reg    <= mem_write_in;
                    indirect_reg     <= indirect_in;
                    byte_reg         <= byte_in;
                    load_regfile_reg <= load_regfile_in;
                    if (valid_in && !flush && (mem_read_in || mem_write_in))
                        state <= indirect_in ? IND : ACC;
                end
                IND: begin
                    if (dmem_resp) begin
                        ind_addr <= dmem_rdata;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (dmem_resp) begin
                        mem_data_reg <= byte_reg ? {{(WIDTH-8){1'b0}}, rdata_byte} : dmem_rdata;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requests derive only from registered state, so they stay stable until dmem_resp.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        case (state)
            IND: begin
                dmem_read    = 1'b1;
                dmem_address = {alu_reg[WIDTH-1:1], 1'b0};
            end
            ACC: begin
                dmem_read  = mem_read_reg;
                dmem_write = mem_write_reg;
                if (byte_reg) begin
                    dmem_address     = acc_addr;
                    dmem_byte_enable = acc_addr[0] ? 2'b10 : 2'b01;
                    dmem_wdata       = {store_data_reg[7:0], store_data_reg[7:0]};
                end else begin
                    dmem_address     = {acc_addr[WIDTH-1:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = store_data_reg;
                end
            end
            default: ;
        endcase
    end

    assign stall_pipeline   = (state != IDLE);
    assign valid_out        = valid_reg & (state == IDLE);
    assign alu_out          = alu_reg;
    assign mem_data_out     = mem_data_reg;
    assign dest_out         = dest_reg;
    assign pc_out           = pc_reg;
    assign load_regfile_out = load_regfile_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed test of ex_mem_stage: ALU pass-through, word/byte/indirect accesses,
// stall hold, flush and asynchronous reset during an access.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, flush;
    logic [15:0] alu_in, store_data_in, pc_in;
    logic [2:0]  dest_in;
    logic        mem_read_in, mem_write_in, indirect_in, byte_in, load_regfile_in;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_read, dmem_write;
    logic [15:0] dmem_address, dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        valid_out;
    logic [15:0] alu_out, mem_data_out, pc_out;
    logic [2:0]  dest_out;
    logic        load_regfile_out, stall_pipeline;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.WIDTH(16), .REGW(3)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
        .alu_in(alu_in), .store_data_in(store_data_in), .dest_in(dest_in), .pc_in(pc_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .indirect_in(indirect_in),
        .byte_in(byte_in), .load_regfile_in(load_regfile_in),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .valid_out(valid_out), .alu_out(alu_out), .mem_data_out(mem_data_out),
        .dest_out(dest_out), .pc_out(pc_out), .load_regfile_out(load_regfile_out),
        .stall_pipeline(stall_pipeline)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; flush = 0; alu_in = 0; store_data_in = 0; pc_in = 0; dest_in = 0;
        mem_read_in = 0; mem_write_in = 0; indirect_in = 0; byte_in = 0; load_regfile_in = 0;
    endtask

    initial begin
        reset_n = 0; dmem_rdata = 0; dmem_resp = 0;
        idle_inputs();
        #3;
        check("rst_valid_out", 16'(valid_out), 16'h0);
        check("rst_stall", 16'(stall_pipeline), 16'h0);
        check("rst_alu_out", alu_out, 16'h0);
        check("rst_mem_data", mem_data_out, 16'h0);
        check("rst_dmem_read", 16'(dmem_read), 16'h0);
        check("rst_byte_en", 16'(dmem_byte_enable), 16'h0);
        @(negedge clk); reset_n = 1;
        step();

        // ADD: visible the cycle after capture, no stall
        valid_in = 1; alu_in = 16'h1234; dest_in = 3'd3; load_regfile_in = 1; pc_in = 16'h0100;
        step();
        check("add_valid_out", 16'(valid_out), 16'h1);
        check("add_alu_out", alu_out, 16'h1234);
        check("add_dest_out", 16'(dest_out), 16'h3);
        check("add_pc_out", pc_out, 16'h0100);
        check("add_lrf_out", 16'(load_regfile_out), 16'h1);
        check("add_stall", 16'(stall_pipeline), 16'h0);
        idle_inputs();
        step();
        check("bubble_valid_out", 16'(valid_out), 16'h0);

        // LDR with a 3-cycle response; upstream inputs change during the stall
        valid_in = 1; mem_read_in = 1; alu_in = 16'h3001; dest_in = 3'd2; load_regfile_in = 1;
        step();
        check("ldr_stall_c1", 16'(stall_pipeline), 16'h1);
        check("ldr_addr", dmem_address, 16'h3000);
        check("ldr_be", 16'(dmem_byte_enable), 16'h3);
        check("ldr_read", 16'(dmem_read), 16'h1);
        check("ldr_write", 16'(dmem_write), 16'h0);
        check("ldr_valid_out_busy", 16'(valid_out), 16'h0);
        alu_in = 16'hFFFF; flush = 1; dest_in = 3'd7;
        step();
        check("ldr_stall_c2", 16'(stall_pipeline), 16'h1);
        check("ldr_addr_held", dmem_address, 16'h3000);
        step();
        check("ldr_stall_c3", 16'(stall_pipeline), 16'h1);
        dmem_resp = 1; dmem_rdata = 16'hBEEF;
        idle_inputs();
        step();
        dmem_resp = 0;
        check("ldr_stall_done", 16'(stall_pipeline), 16'h0);
        check("ldr_valid_out", 16'(valid_out), 16'h1);
        check("ldr_mem_data", mem_data_out, 16'hBEEF);
        check("ldr_alu_held", alu_out, 16'h3001);
        check("ldr_dest_held", 16'(dest_out), 16'h2);
        check("ldr_req_drop", 16'(dmem_read), 16'h0);

        // Response while idle must be ignored
        dmem_resp = 1; dmem_rdata = 16'h1111;
        step();
        step();
        dmem_resp = 0;
        check("idle_resp_stall", 16'(stall_pipeline), 16'h0);
        check("idle_resp_mem_data", mem_data_out, 16'hBEEF);

        // LDB odd address, 1-cycle response
        valid_in = 1; mem_read_in = 1; byte_in = 1; alu_in = 16'h4005;
        dmem_resp = 1; dmem_rdata = 16'hA55A;
        step();
        idle_inputs();
        check("ldb_odd_addr", dmem_address, 16'h4005);
        check("ldb_odd_be", 16'(dmem_byte_enable), 16'h2);
        step();
        dmem_resp = 0;
        check("ldb_odd_valid", 16'(valid_out), 16'h1);
        check("ldb_odd_data", mem_data_out, 16'h00A5);

        // LDB even address
        valid_in = 1; mem_read_in = 1; byte_in = 1; alu_in = 16'h4004;
        dmem_resp = 1; dmem_rdata = 16'hA55A;
        step();
        idle_inputs();
        check("ldb_even_addr", dmem_address, 16'h4004);
        check("ldb_even_be", 16'(dmem_byte_enable), 16'h1);
        step();
        dmem_resp = 0;
        check("ldb_even_data", mem_data_out, 16'h005A);

        // STB odd address
        valid_in = 1; mem_write_in = 1; byte_in = 1; alu_in = 16'h5001; store_data_in = 16'h12CD;
        step();
        idle_inputs();
        check("stb_write", 16'(dmem_write), 16'h1);
        check("stb_read", 16'(dmem_read), 16'h0);
        check("stb_be", 16'(dmem_byte_enable), 16'h2);
        check("stb_wdata", dmem_wdata, 16'hCDCD);
        check("stb_addr", dmem_address, 16'h5001);
        dmem_resp = 1;
        step();
        dmem_resp = 0;
        check("stb_valid", 16'(valid_out), 16'h1);
        check("stb_stall", 16'(stall_pipeline), 16'h0);

        // STR word, odd effective address aligned down
        valid_in = 1; mem_write_in = 1; alu_in = 16'h2003; store_data_in = 16'hABCD;
        step();
        idle_inputs();
        check("str_addr", dmem_address, 16'h2002);
        check("str_be", 16'(dmem_byte_enable), 16'h3);
        check("str_wdata", dmem_wdata, 16'hABCD);
        dmem_resp = 1;
        step();
        dmem_resp = 0;

        // LDI: pointer fetch then data fetch
        valid_in = 1; mem_read_in = 1; indirect_in = 1; alu_in = 16'h6000;
        step();
        idle_inputs();
        check("ldi_ind_stall", 16'(stall_pipeline), 16'h1);
        check("ldi_ind_read", 16'(dmem_read), 16'h1);
        check("ldi_ind_addr", dmem_address, 16'h6000);
        dmem_resp = 1; dmem_rdata = 16'h7002;
        step();
        check("ldi_acc_stall", 16'(stall_pipeline), 16'h1);
        check("ldi_acc_addr", dmem_address, 16'h7002);
        check("ldi_acc_be", 16'(dmem_byte_enable), 16'h3);
        check("ldi_valid_busy", 16'(valid_out), 16'h0);
        dmem_rdata = 16'h0042;
        step();
        dmem_resp = 0;
        check("ldi_valid", 16'(valid_out), 16'h1);
        check("ldi_data", mem_data_out, 16'h0042);

        // Flush at capture: squashed, no request
        valid_in = 1; flush = 1; mem_read_in = 1; alu_in = 16'h1000;
        step();
        idle_inputs();
        check("flush_valid", 16'(valid_out), 16'h0);
        check("flush_stall", 16'(stall_pipeline), 16'h0);
        check("flush_read", 16'(dmem_read), 16'h0);

        // Reset in the middle of an access
        valid_in = 1; mem_read_in = 1; alu_in = 16'h3000;
        step();
        idle_inputs();
        check("rstacc_read_before", 16'(dmem_read), 16'h1);
        #2 reset_n = 0;
        #1;
        check("rstacc_read", 16'(dmem_read), 16'h0);
        check("rstacc_stall", 16'(stall_pipeline), 16'h0);
        check("rstacc_valid", 16'(valid_out), 16'h0);
        @(negedge clk); reset_n = 1;
        step();
        check("rstacc_stays_idle", 16'(stall_pipeline), 16'h0);
        check("rstacc_no_valid", 16'(valid_out), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
